serial_add_sequencer: RTL and testbench

SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

---
 rtl/add_seq_pkg.sv | 13 +
 rtl/nibble_adder_slice.sv | 22 ++
 rtl/serial_add_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_serial_add_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package add_seq_pkg;

  localparam int unsigned NIBBLE_W      = 4;
  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : add_seq_pkg

// File: rtl/nibble_adder_slice.sv
// Combinational 4-bit adder slice with carry in/out, reused every RUN cycle.
module nibble_adder_slice
  import add_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                cout_o
);

  logic [NIBBLE_W:0] total_c;

  // Widen all terms so the carry lands in the top bit.
  always_comb begin
    total_c = (NIBBLE_W+1)'(a_i) + (NIBBLE_W+1)'(b_i) + (NIBBLE_W+1)'(cin_i);
  end

  assign sum_o  = total_c[NIBBLE_W-1:0];
  assign cout_o = total_c[NIBBLE_W];

endmodule : nibble_adder_slice

// File: rtl/serial_add_sequencer.sv
// Nibble-serial WIDTH-bit add/subtract with valid/ready handshakes on both sides.
module serial_add_sequencer
  import add_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned NIBBLES  = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned LAST_IDX = NIBBLES - 1;

  // Elaboration guard: the datapath only works on whole nibbles.
  if ((WIDTH == 0) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
    $error("serial_add_sequencer: WIDTH must be a non-zero multiple of 4");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;          // B already inverted for subtract
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic                accept_c;
  logic                last_c;
  logic [NIBBLE_W-1:0] slice_a_c;
  logic [NIBBLE_W-1:0] slice_b_c;
  logic [NIBBLE_W-1:0] slice_sum_c;
  logic                slice_cout_c;
  logic [WIDTH-1:0]    sum_next_c;

  assign accept_c = in_valid && (state_q == IDLE);
  assign last_c   = (k_q == IDX_W'(LAST_IDX));

  // Select the active nibble of each operand.
  always_comb begin
    slice_a_c = '0;
    slice_b_c = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (k_q == IDX_W'(i)) begin
        slice_a_c = a_q[i*NIBBLE_W +: NIBBLE_W];
        slice_b_c = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  nibble_adder_slice u_slice (
    .a_i    (slice_a_c),
    .b_i    (slice_b_c),
    .cin_i  (carry_q),
    .sum_o  (slice_sum_c),
    .cout_o (slice_cout_c)
  );

  // Merge the slice result into the active nibble of the partial sum.
  always_comb begin
    sum_next_c = sum_q;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (k_q == IDX_W'(i)) begin
        sum_next_c[i*NIBBLE_W +: NIBBLE_W] = slice_sum_c;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a result pop always returns to IDLE before a new accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c)  state_d = RUN;
      RUN:     if (last_c)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Output and datapath next values; handshake flags follow the next state.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    k_d         = k_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub;
          k_d     = '0;
        end
      end
      RUN: begin
        sum_d   = sum_next_c;
        carry_d = slice_cout_c;
        if (last_c) begin
          cout_d = slice_cout_c;
          ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                   (slice_sum_c[NIBBLE_W-1] != a_q[WIDTH-1]);
          zero_d = (sum_next_c == '0);
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Handshake output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Operand, carry, index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_carry = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule : serial_add_sequencer

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer at WIDTH=32 with hand-computed results.
module tb_serial_add_sequencer;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ovf;
  logic             out_zero;

  int total;
  int bad;
  int op_id;

  serial_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s (op %0d): got 0x%08h want 0x%08h", tag, op_id, obs, exp);
    end
  endtask

  // Issue one request at the current negedge (sequencer idle) and check the result.
  // Accept edge E0, nibbles on E1..E8, out_valid seen at the 9th negedge after launch.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] es, input logic ec, input logic eo,
                        input logic ez, input bit pop);
    int cycles;
    op_id++;
    out_ready = pop;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_sub   = 1'($urandom_range(1, 0));
    check("run_in_ready", 32'(in_ready), 32'd0);
    check("run_out_valid", 32'(out_valid), 32'd0);
    cycles = 1;
    while (!out_valid && cycles < 40) begin
      in_valid = 1'($urandom_range(1, 0));
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    check("latency", 32'(cycles), 32'd9);
    check("sum", out_sum, es);
    check("carry", 32'(out_carry), 32'(ec));
    check("ovf", 32'(out_ovf), 32'(eo));
    check("zero", 32'(out_zero), 32'(ez));
    check("done_in_ready", 32'(in_ready), 32'd0);
    if (pop) begin
      @(negedge clk);
      check("pop_out_valid", 32'(out_valid), 32'd0);
      check("pop_in_ready", 32'(in_ready), 32'd1);
      check("hold_sum", out_sum, es);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    total     = 0;
    bad       = 0;
    op_id     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;

    // Reset values while rst_n is held low.
    #23;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum", out_sum, 32'd0);
    check("rst_carry", 32'(out_carry), 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);
    check("rst_zero", 32'(out_zero), 32'd0);

    // Release and accept on the very first rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);

    // 5 - 7 with consumer stalled, then a request queued against the pop.
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_a     = 32'h0000_0001;
      in_b     = 32'h0000_0001;
      in_sub   = 1'b0;
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_sum", out_sum, 32'hFFFF_FFFE);
      check("stall_carry", 32'(out_carry), 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 32'h0000_0007;
    in_b      = 32'h0000_0005;
    in_sub    = 1'b1;
    @(negedge clk);
    check("pop_not_accepted", 32'(in_ready), 32'd1);
    check("pop_valid_low", 32'(out_valid), 32'd0);
    check("idle_hold_sum", out_sum, 32'hFFFF_FFFE);
    run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b1);

    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    run_op(32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    run_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 32'hEFBE_D000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Abort after the third RUN edge.
    op_id++;
    in_a     = 32'h1234_5678;
    in_b     = 32'h1111_1111;
    in_sub   = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_sum", out_sum, 32'd0);
    check("abort_carry", 32'(out_carry), 32'd0);
    check("abort_ovf", 32'(out_ovf), 32'd0);
    check("abort_zero", 32'(out_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);

    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_add_sequencer
